struct_packet_fifo: RTL and testbench
=====================================

Name: struct_packet_fifo

Overview:
Parametrised successor to the single-packet struct transform. Accepts {data, tag} packets over a valid/ready handshake and buffers them in a DEPTH-entry packed-struct FIFO. Each packet is optionally transformed before storage: data + INC, tag ^ TAG_MASK. The FIFO sits between a packet producer and a downstream consumer that may stall.

Parameters:
DATA_W, 8, width of packet data field
TAG_W, 4, width of packet tag field
DEPTH, 4, FIFO entries; power of two, >= 2
INC, 1, constant added to data when the transform is applied (DATA_W bits)
TAG_MASK, 4'b1010, XOR mask applied to tag when the transform is applied (TAG_W bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer presents a packet
in_ready  out  1  FIFO can accept a packet
in_data  in  DATA_W  packet data
in_tag  in  TAG_W  packet tag
in_proc  in  1  1 = apply transform; 0 = pass packet unchanged
out_valid  out  1  head packet available
out_ready  in  1  consumer accepts head packet
out_data  out  DATA_W  head packet data
out_tag  out  TAG_W  head packet tag
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: count=0, read and write pointers=0, in_ready=1, out_valid=0, out_data=0, out_tag=0. Storage contents are not reset.
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends on registered state only, not on out_ready, so a push into a full FIFO is never accepted, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_data and out_tag are taken from the head entry (first-word-fall-through). They read 0 when empty.
- Transform is applied at write time.
  - data = in_data + INC, truncated to DATA_W (wraps modulo 2^DATA_W; no carry out).
  - tag = in_tag ^ TAG_MASK.
  - When in_proc=0, both fields are stored unchanged.
- Latency: a packet pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop, with 0 < count < DEPTH: both happen, count is unchanged, and ordering is preserved.
- Push while empty: count goes 0 to 1; out_valid rises the next cycle.
- Pop while in_valid=1 and full: pop happens, push is refused (in_ready=0). in_ready rises the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Out-of-protocol drives must not corrupt state:
  - out_ready while empty: pop is ignored.
  - in_valid while full: push is ignored.
- Reset asserted mid-operation clears everything asynchronously. Buffered packets are lost; no partial output survives.
- Holding out_valid: while out_valid=1 and out_ready=0, out_data and out_tag stay stable.

Decomposition:
- Shared package struct_pkt_pkg holds:
  - default widths PKT_DATA_W=8 and PKT_TAG_W=4;
  - default TAG_MASK constant;
  - typedef packet_t (packed: data, tag) at the default widths.
- Inside the module, a local packed struct with the same field order is declared from DATA_W/TAG_W for storage.
- One sub-module, struct_pkt_xform: purely combinational add/XOR with a proc select, parametrised like the parent. The parent owns the storage array, pointers and counter.

Test Plan:
- Reset, then push {data=8'h10, tag=4'h3, proc=1} -> next cycle out_valid=1, out_data=8'h11, out_tag=4'h9, count=1.
- Push {8'hFF, 4'hF, proc=1} -> out_data=8'h00 (wrap), out_tag=4'h5. Push {8'h42, 4'h6, proc=0} -> out_data=8'h42, out_tag=4'h6 unchanged.
- Fill to 4 with out_ready=0 -> in_ready=0, count=4. A 5th in_valid packet is not stored. Then drain with out_ready=1 -> 4 packets return in order, count ends 0, out_valid=0.
- Steady stream with in_valid=out_ready=1 at count=2 -> count holds at 2, one packet in and one out per cycle, no loss or reordering over 20 packets.
- Full with in_valid=1 and out_ready=1 in the same cycle -> one pop, no push, count=3; the held packet is accepted the next cycle.
- Assert rst_n=0 asynchronously with count=3 -> count=0, out_valid=0, in_ready=1 immediately. After release, the first push emerges correctly.

Source files
------------

// File: rtl/struct_pkt_pkg.sv
// Shared packet definitions for the struct packet FIFO family.
// Default widths, default tag mask and the default-width packet type.
package struct_pkt_pkg;

  localparam int PKT_DATA_W = 8;
  localparam int PKT_TAG_W  = 4;

  localparam logic [PKT_TAG_W-1:0] PKT_TAG_MASK = 4'b1010;

  typedef struct packed {
    logic [PKT_DATA_W-1:0] data;
    logic [PKT_TAG_W-1:0]  tag;
  } packet_t;

endpackage

// File: rtl/struct_pkt_xform.sv
// Combinational packet transform: data + INC (wrapping), tag ^ TAG_MASK.
// When proc is low the packet passes through untouched.
module struct_pkt_xform
  import struct_pkt_pkg::*;
#(
  parameter int                 DATA_W   = PKT_DATA_W,
  parameter int                 TAG_W    = PKT_TAG_W,
  parameter logic [DATA_W-1:0]  INC      = DATA_W'(1),
  parameter logic [TAG_W-1:0]   TAG_MASK = TAG_W'(PKT_TAG_MASK)
) (
  input  logic              proc,
  input  logic [DATA_W-1:0] raw_data,
  input  logic [TAG_W-1:0]  raw_tag,
  output logic [DATA_W-1:0] xf_data,
  output logic [TAG_W-1:0]  xf_tag
);

  // Sum is kept at DATA_W bits so the carry out is dropped on purpose.
  logic [DATA_W-1:0] sum_data;
  assign sum_data = raw_data + INC;

  assign xf_data = proc ? sum_data : raw_data;
  assign xf_tag  = proc ? (raw_tag ^ TAG_MASK) : raw_tag;

endmodule

// File: rtl/struct_packet_fifo.sv
// First-word-fall-through packet FIFO with optional write-time transform.
// in_ready depends on registered occupancy only, so a full FIFO never accepts.
module struct_packet_fifo
  import struct_pkt_pkg::*;
#(
  parameter int                 DATA_W   = PKT_DATA_W,
  parameter int                 TAG_W    = PKT_TAG_W,
  parameter int                 DEPTH    = 4,
  parameter logic [DATA_W-1:0]  INC      = DATA_W'(1),
  parameter logic [TAG_W-1:0]   TAG_MASK = TAG_W'(PKT_TAG_MASK)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       in_proc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;
  entry_t           wr_entry, head;

  struct_pkt_xform #(
    .DATA_W   (DATA_W),
    .TAG_W    (TAG_W),
    .INC      (INC),
    .TAG_MASK (TAG_MASK)
  ) u_xform (
    .proc     (in_proc),
    .raw_data (in_data),
    .raw_tag  (in_tag),
    .xf_data  (wr_entry.data),
    .xf_tag   (wr_entry.tag)
  );

  assign in_ready  = (count_reg != FULL_CNT);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is deliberately left out of reset; only pointers and count clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Head is masked to zero when empty so stale storage never leaks out.
  assign head     = mem[rd_ptr_reg];
  assign out_data = out_valid ? head.data : '0;
  assign out_tag  = out_valid ? head.tag  : '0;
  assign count    = count_reg;

endmodule

// File: tb/tb_struct_packet_fifo.sv
// Bench for struct_packet_fifo: directed scenarios plus a random phase,
// checked against a queue-based reference of the packet FIFO.
module tb_struct_packet_fifo;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;
  localparam int INC_V  = 1;
  localparam logic [3:0] MASK_V = 4'b1010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_proc, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] in_tag, out_tag;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] t;
  } pkt_t;

  pkt_t q[$];

  struct_packet_fifo #(
    .DATA_W   (DATA_W),
    .TAG_W    (TAG_W),
    .DEPTH    (DEPTH),
    .INC      (8'(INC_V)),
    .TAG_MASK (MASK_V)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_proc   (in_proc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Compare every observable output against the reference queue.
  task automatic check_model();
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_tag", 32'(out_tag), 32'(q[0].t));
    end else begin
      chk("out_data_empty", 32'(out_data), 32'h0);
      chk("out_tag_empty", 32'(out_tag), 32'h0);
    end
  endtask

  // One clock: drive at negedge, check pre-edge outputs, update reference at posedge.
  task automatic cycle(input bit v, input logic [7:0] d, input logic [3:0] t,
                       input bit p, input bit r);
    bit   exp_push, exp_pop;
    pkt_t e;
    in_valid = v; in_data = d; in_tag = t; in_proc = p; out_ready = r;
    #1;
    check_model();
    exp_push = v && (q.size() != DEPTH);
    exp_pop  = r && (q.size() != 0);
    @(posedge clk);
    if (exp_pop) begin
      e = q.pop_front();
      $display("pop  data=%02h tag=%h", e.d, e.t);
    end
    if (exp_push) begin
      e.d = p ? 8'((int'(d) + INC_V) % 256) : d;
      e.t = p ? (t ^ MASK_V) : t;
      q.push_back(e);
      $display("push data=%02h tag=%h proc=%0d stored=%02h/%h", d, t, p, e.d, e.t);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; in_tag = 0; in_proc = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset_count", 32'(count), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_out_tag", 32'(out_tag), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Transform cases, each brought to the head of an empty FIFO.
    cycle(1, 8'h10, 4'h3, 1, 0);
    #1;
    chk("first_valid", 32'(out_valid), 1);
    chk("first_data", 32'(out_data), 32'h11);
    chk("first_tag", 32'(out_tag), 32'h9);
    chk("first_count", 32'(count), 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 8'hFF, 4'hF, 1, 0);
    #1;
    chk("wrap_data", 32'(out_data), 32'h00);
    chk("wrap_tag", 32'(out_tag), 32'h5);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 8'h42, 4'h6, 0, 0);
    #1;
    chk("pass_data", 32'(out_data), 32'h42);
    chk("pass_tag", 32'(out_tag), 32'h6);
    cycle(0, 0, 0, 0, 1);

    // Fill, refuse a fifth packet, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h20 + i), 4'(i), 1, 0);
    #1;
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    cycle(1, 8'hAA, 4'hC, 0, 0);
    #1;
    chk("full_count_after_5th", 32'(count), 4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    #1;
    chk("drained_count", 32'(count), 0);
    chk("drained_out_valid", 32'(out_valid), 0);

    // Steady stream at occupancy 2.
    cycle(1, 8'h01, 4'h1, 0, 0);
    cycle(1, 8'h02, 4'h2, 0, 0);
    for (int i = 0; i < 20; i++)
      cycle(1, 8'($urandom), 4'($urandom), 1'($urandom), 1);
    #1;
    chk("stream_count", 32'(count), 2);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Full with simultaneous push and pop: pop only, push lands next cycle.
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h30 + i), 4'(i), 0, 0);
    cycle(1, 8'h77, 4'h7, 0, 1);
    #1;
    chk("full_both_count", 32'(count), 3);
    chk("full_both_in_ready", 32'(in_ready), 1);
    cycle(1, 8'h77, 4'h7, 0, 0);
    #1;
    chk("held_accept_count", 32'(count), 4);
    cycle(0, 0, 0, 0, 1);

    // Asynchronous reset mid-operation at occupancy 3.
    in_valid = 0; out_ready = 0;
    @(posedge clk);
    #2;
    chk("pre_reset_count", 32'(count), 3);
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_in_ready", 32'(in_ready), 1);
    chk("async_out_data", 32'(out_data), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'h5A, 4'h0, 1, 0);
    #1;
    chk("post_reset_data", 32'(out_data), 32'h5B);
    chk("post_reset_tag", 32'(out_tag), 32'hA);
    cycle(0, 0, 0, 0, 1);

    // Random traffic against the reference queue.
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    #1;
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
